// File: rtl/microwire_rd_slave.sv
// Read-only 93C46-style (x16) Microwire slave. CS/SK/DI are oversampled in the clk
// domain; words are fetched from external storage through a synchronous read port.
module microwire_rd_slave #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              sk,
  input  logic              di,
  output logic              do_o,
  output logic              do_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    OPC    = 3'd1,
    ADDR   = 3'd2,
    FETCH  = 3'd3,
    DATA   = 3'd4,
    IGNORE = 3'd5
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sk_sync;
  logic [SYNC_STAGES-1:0] di_sync;
  logic                   sk_q;
  logic                   cs_s;
  logic                   di_s;
  logic                   ske;
  logic [DATA_W-1:0]      shreg;
  logic [CNT_W-1:0]       bit_cnt;
  logic [1:0]             fetch_cnt;
  logic                   fetch_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync <= '0;
      sk_sync <= '0;
      di_sync <= '0;
      sk_q    <= 1'b0;
    end else begin
      cs_sync <= {cs_sync[SYNC_STAGES-2:0], cs};
      sk_sync <= {sk_sync[SYNC_STAGES-2:0], sk};
      di_sync <= {di_sync[SYNC_STAGES-2:0], di};
      sk_q    <= sk_sync[SYNC_STAGES-1];
    end
  end

  assign cs_s = cs_sync[SYNC_STAGES-1];
  assign di_s = di_sync[SYNC_STAGES-1];
  assign ske  = sk_sync[SYNC_STAGES-1] & ~sk_q;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      do_o       <= 1'b0;
      do_oe      <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      fetch_cnt  <= 2'd0;
      fetch_pend <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      // Storage data is stable two clk after the strobe; load on the third edge.
      if (fetch_pend) begin
        if (fetch_cnt == 2'd2) begin
          shreg      <= mem_rdata;
          fetch_pend <= 1'b0;
          if (state == FETCH) state <= DATA;
        end else begin
          fetch_cnt <= fetch_cnt + 2'd1;
        end
      end
      if (!cs_s) begin
        state      <= IDLE;
        do_o       <= 1'b0;
        do_oe      <= 1'b0;
        fetch_pend <= 1'b0;
      end else if (ske) begin
        case (state)
          IDLE: begin
            if (di_s) begin
              state   <= OPC;
              bit_cnt <= '0;
              shreg   <= '0;
            end
          end
          OPC: begin
            shreg <= {shreg[DATA_W-2:0], di_s};
            if (bit_cnt == CNT_W'(1)) begin
              bit_cnt <= '0;
              state   <= ({shreg[0], di_s} == 2'b10) ? ADDR : IGNORE;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          ADDR: begin
            shreg <= {shreg[DATA_W-2:0], di_s};
            if (bit_cnt == CNT_W'(ADDR_W - 1)) begin
              mem_addr   <= {shreg[ADDR_W-2:0], di_s};
              do_oe      <= 1'b1;
              do_o       <= 1'b0;
              mem_rd     <= 1'b1;
              fetch_pend <= 1'b1;
              fetch_cnt  <= 2'd0;
              bit_cnt    <= '0;
              state      <= FETCH;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          DATA: begin
            do_o  <= shreg[DATA_W-1];
            shreg <= {shreg[DATA_W-2:0], 1'b0};
            // Last bit of the word goes out now; prefetch the next address.
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              bit_cnt    <= '0;
              mem_addr   <= mem_addr + ADDR_W'(1);
              mem_rd     <= 1'b1;
              fetch_pend <= 1'b1;
              fetch_cnt  <= 2'd0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          IGNORE: do_oe <= 1'b0;
          FETCH:  ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_microwire_rd_slave.sv
// Bench for microwire_rd_slave: table of directed commands, random commands, and a
// reset-during-read sequence, all checked against a bit-stream reference model.
module tb_microwire_rd_slave;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;
  localparam int HALF   = 10;

  logic              clk;
  logic              rst_n;
  logic              cs;
  logic              sk;
  logic              di;
  logic              do_o;
  logic              do_oe;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  microwire_rd_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .sk(sk), .di(di), .do_o(do_o), .do_oe(do_oe),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .busy(busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external storage: data appears two clk after the strobe
  logic [DATA_W-1:0] mem [64];
  logic [DATA_W-1:0] mem_pipe;
  always @(posedge clk) begin
    if (mem_rd) mem_pipe <= mem[mem_addr];
    mem_rdata <= mem_pipe;
  end

  logic [ADDR_W-1:0] rd_obs_q[$];
  always @(posedge clk) if (rst_n && mem_rd) rd_obs_q.push_back(mem_addr);

  // scoreboard
  int n_checks = 0;
  int n_fail   = 0;
  logic              tx_q[$];
  logic              exp_do_q[$];
  logic              exp_oe_q[$];
  logic              exp_busy_q[$];
  logic [ADDR_W-1:0] exp_q[$];
  int                rd_base;

  typedef struct {
    int          lead;
    logic [1:0]  opc;
    logic [5:0]  addr;
    int          n_data;
    int          trunc;
    int          exp_rds;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic build(input int lead, input logic [1:0] opc, input logic [5:0] addr,
                       input int n_data, input int trunc);
    tx_q.delete();
    repeat (lead) tx_q.push_back(1'b0);
    tx_q.push_back(1'b1);
    tx_q.push_back(opc[1]);
    tx_q.push_back(opc[0]);
    for (int i = ADDR_W - 1; i >= 0; i--) tx_q.push_back(addr[i]);
    repeat (n_data) tx_q.push_back(1'($urandom_range(0, 1)));
    repeat (trunc) void'(tx_q.pop_back());
  endtask

  // Reference: parse the DI stream edge by edge and predict DO/OE/busy after each edge.
  task automatic model();
    int   start;
    int   rel;
    int   k;
    int   wa;
    logic is_read;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] w;
    exp_do_q.delete(); exp_oe_q.delete(); exp_busy_q.delete(); exp_q.delete();
    start = -1; is_read = 1'b0; a = '0;
    for (int e = 0; e < tx_q.size(); e++) begin
      if (start < 0 && tx_q[e]) start = e;
      if (start < 0) begin
        exp_do_q.push_back(1'b0); exp_oe_q.push_back(1'b0); exp_busy_q.push_back(1'b0);
      end else begin
        rel = e - start;
        if (rel == 2) is_read = tx_q[start+1] && !tx_q[start+2];
        if (rel <= 2 || !is_read) begin
          exp_do_q.push_back(1'b0); exp_oe_q.push_back(1'b0); exp_busy_q.push_back(1'b1);
        end else if (rel <= 2 + ADDR_W) begin
          a = {a[ADDR_W-2:0], tx_q[e]};
          exp_do_q.push_back(1'b0);
          exp_oe_q.push_back(rel == 2 + ADDR_W);
          exp_busy_q.push_back(1'b1);
          if (rel == 2 + ADDR_W) exp_q.push_back(a);
        end else begin
          k  = rel - 3 - ADDR_W;
          wa = (int'(a) + k / DATA_W) % 64;
          w  = mem[wa];
          exp_do_q.push_back(w[DATA_W - 1 - k % DATA_W]);
          exp_oe_q.push_back(1'b1);
          exp_busy_q.push_back(1'b1);
          if (k % DATA_W == DATA_W - 1) exp_q.push_back(ADDR_W'((int'(a) + k / DATA_W + 1) % 64));
        end
      end
    end
  endtask

  // driver: one SK period, returns at the end of the high phase
  task automatic sk_edge(input logic b);
    @(negedge clk);
    di = b;
    sk = 1'b0;
    repeat (HALF) @(negedge clk);
    sk = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic check_rds(input int exp_rds);
    check("rd_count", rd_obs_q.size() - rd_base, exp_q.size());
    if (exp_rds >= 0) check("rd_count_tbl", rd_obs_q.size() - rd_base, exp_rds);
    for (int i = 0; i < exp_q.size() && rd_base + i < rd_obs_q.size(); i++)
      check($sformatf("rd_addr%0d", i), rd_obs_q[rd_base + i], exp_q[i]);
  endtask

  task automatic end_txn(input int exp_rds);
    @(negedge clk);
    sk = 1'b0;
    repeat (HALF) @(negedge clk);
    check_rds(exp_rds);
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    check("busy_after_cs", busy, 1'b0);
    check("oe_after_cs", do_oe, 1'b0);
    check("do_after_cs", do_o, 1'b0);
  endtask

  task automatic run_txn(input logic keep_cs, input int exp_rds);
    model();
    rd_base = rd_obs_q.size();
    @(negedge clk);
    cs = 1'b1;
    sk = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int e = 0; e < tx_q.size(); e++) begin
      sk_edge(tx_q[e]);
      check($sformatf("do e%0d", e), do_o, exp_do_q[e]);
      check($sformatf("oe e%0d", e), do_oe, exp_oe_q[e]);
      check($sformatf("busy e%0d", e), busy, exp_busy_q[e]);
    end
    if (!keep_cs) end_txn(exp_rds);
  endtask

  initial begin
    rst_n = 1'b0; cs = 1'b0; sk = 1'b0; di = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = DATA_W'($urandom);
    mem[5] = 16'hA5C3; mem[63] = 16'h8001; mem[0] = 16'h7FFE;
    mem[2] = 16'h1234; mem[9] = 16'hBEEF;

    vecs[0] = '{0, 2'b10, 6'd5,        16, 0, 2};
    vecs[1] = '{0, 2'b10, 6'd63,       33, 0, 3};
    vecs[2] = '{3, 2'b10, 6'd2,        16, 0, 2};
    vecs[3] = '{0, 2'b00, 6'b110000,   20, 0, 0};
    vecs[4] = '{0, 2'b10, 6'd9,         0, 3, 0};
    vecs[5] = '{0, 2'b10, 6'd9,        16, 0, 2};

    repeat (3) @(negedge clk);
    check("rst_do", do_o, 1'b0);
    check("rst_oe", do_oe, 1'b0);
    check("rst_rd", mem_rd, 1'b0);
    check("rst_addr", mem_addr, 0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      build(vecs[v].lead, vecs[v].opc, vecs[v].addr, vecs[v].n_data, vecs[v].trunc);
      run_txn(1'b0, vecs[v].exp_rds);
    end

    for (int r = 0; r < 10; r++) begin
      logic [1:0] opc;
      opc = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b10;
      build($urandom_range(0, 2), opc, 6'($urandom), $urandom_range(0, 40), 0);
      run_txn(1'b0, -1);
    end

    // reset while bit 7 of the first data word is on DO
    build(0, 2'b10, 6'd7, 9, 0);
    run_txn(1'b1, 1);
    check_rds(1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_oe", do_oe, 1'b0);
    check("mid_rst_do", do_o, 1'b0);
    check("mid_rst_rd", mem_rd, 1'b0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_busy", busy, 1'b0);
    sk = 1'b0;
    di = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (HALF) @(negedge clk);
    for (int e = 0; e < 5; e++) begin
      sk_edge(1'b0);
      check($sformatf("post_rst_do%0d", e), do_o, 1'b0);
      check($sformatf("post_rst_oe%0d", e), do_oe, 1'b0);
      check($sformatf("post_rst_busy%0d", e), busy, 1'b0);
    end
    @(negedge clk);
    sk = 1'b0;
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    build(0, 2'b10, 6'd9, 16, 0);
    run_txn(1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/microwire_rd_slave.md
Name: microwire_rd_slave

Overview:
- Clocked Microwire (93C46-style, x16 organisation) read-only slave.
- Consumes the bit-banged CS/SK/DI lines that the upstream bus-decode state machine produces, and returns serial data on DO for that stage's SDRD sampling.
- Word storage is external; the block fetches each word through a simple synchronous read port.
- Everything runs on the system clock; CS, SK and DI are asynchronous inputs and are oversampled.

Parameters:
- ADDR_W, 6, word address width (64 words).
- DATA_W, 16, word width; bits are shifted out MSB first.
- SYNC_STAGES, 2, synchroniser flops on cs, sk and di (minimum 2).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cs  in  1  chip select, active high, asynchronous.
- sk  in  1  serial clock, asynchronous; its rising edge is detected in the clk domain.
- di  in  1  serial data in, asynchronous.
- do_o  out  1  serial data out.
- do_oe  out  1  high while do_o is driven; the pad is tri-stated otherwise.
- mem_addr  out  ADDR_W  word address presented to storage.
- mem_rd  out  1  one-clk read strobe.
- mem_rdata  in  DATA_W  word data; valid on the second clk after mem_rd and held until the next mem_rd.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n low): state=IDLE, do_o=0, do_oe=0, mem_rd=0, mem_addr=0, busy=0, shift register and bit counter cleared. Synchronisers clear to 0.
- Synchronisation: cs, sk and di each pass through SYNC_STAGES flops. The SK rising edge (ske) is detected from the last two synchronised sk samples. DI is sampled on the ske cycle.
- Timing contract: SK high and low phases must each be at least SYNC_STAGES+4 clk. The block is not required to tolerate faster SK.
- CS low (synchronised): overrides everything within 1 clk. State goes to IDLE, do_oe=0, do_o=0, and any fetch in flight is abandoned. mem_addr keeps its value.
- State IDLE:
  - On ske with cs=1 and di=1 (start bit), go to OPC and set bit count=0.
  - On ske with di=0, stay in IDLE; leading zeros are ignored.
- State OPC: shift in 2 opcode bits on 2 ske.
  - Opcode 10 (READ): go to ADDR.
  - Any other opcode (EWEN/EWDS/WRITE/ERASE/WRAL/ERAL): go to IGNORE.
- State ADDR: shift in ADDR_W address bits MSB first. On the ske that captures the last bit:
  - mem_addr takes the captured address.
  - do_oe=1 and do_o=0 (the dummy zero).
  - mem_rd pulses on the following clk.
  - Go to FETCH.
- State FETCH: load the shift register from mem_rdata on the second clk after mem_rd, then go to DATA. do_o stays 0.
- State DATA: on each ske, do_o takes the next bit, MSB first.
  - The first ske in DATA drives bit DATA_W-1.
  - On the ske that drives bit 0: mem_addr increments (wraps (2^ADDR_W)-1 to 0), mem_rd pulses on the next clk, and the new word loads 2 clk later.
  - The next ske drives the new word's MSB, with no dummy bit between words (sequential read).
  - Continues for as long as CS stays high.
- State IGNORE: do_oe=0. ske is ignored until CS goes low.
- do_o changes only on ske cycles, except at reset, CS drop, and the transition into ADDR's dummy bit.
- A start bit is only recognised from IDLE. After a READ, the host must drop CS before the next command.
- Reset asserted mid-read: do_oe drops asynchronously. After release the block waits in IDLE. If CS is already high at release, a start bit is still required.

Test Plan:
- Synthesise SK at 10 clk/phase, CS=1, DI = 1,1,0, then address 000101; mem returns 0xA5C3 for addr 5. Required: dummy 0, then DO bits 1010010111000011 on successive ske; mem_rd pulses exactly once with mem_addr=5; do_oe=1 from the last address bit.
- Same READ at address 63 (mem 63=0x8001, 0=0x7FFE), holding CS for 33 data edges. Required: DO = 0x8001 then 0x7FFE with no gap; second mem_rd has mem_addr=0 (wrap).
- Three leading 0s on DI, then a READ of addr 2 = 0x1234. Required: leading zeros ignored, and the read is correct.
- EWEN command (1,00,11xxxx) with CS held for 20 extra ske. Required: do_oe stays 0, mem_rd never pulses, and busy=1 until CS drops.
- Drop CS after 3 address bits, then issue a full READ of addr 9 = 0xBEEF. Required: the first fragment produces no mem_rd, and the second read returns 0xBEEF.
- Assert rst_n low during bit 7 of a data word. Required: do_oe=0 immediately, and all outputs at reset values. After release with CS still high and no start bit: DO stays 0 and do_oe stays 0. A subsequent full READ works.
